// File: rtl/parameters_pkg.sv
// Ed448 field constants and shared types for the point-encoding datapath.
// Field prime p = 2^448 - 2^224 - 1; Montgomery radix R = 2^448.
package parameters_pkg;

  localparam int unsigned DATA_WIDTH = 448;
  localparam int unsigned ENC_WIDTH  = 456;

  localparam logic [DATA_WIDTH-1:0] P         = {{223{1'b1}}, 1'b0, {224{1'b1}}};
  localparam logic [DATA_WIDTH-1:0] P_MINUS_2 = {{223{1'b1}}, 1'b0, {222{1'b1}}, 2'b01};
  // R mod p = 2^224 + 1
  localparam logic [DATA_WIDTH-1:0] R_MOD_P   = {{223{1'b0}}, 1'b1, {223{1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] FIELD_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE,
    INV_SQR,
    INV_MUL,
    MUL_X,
    MUL_Y,
    FROM_X,
    FROM_Y,
    CANON,
    DONE
  } enc_state_t;

endpackage

// File: rtl/point_encode_mont_mul.sv
// Digit-serial (64-bit) Montgomery multiplier: result = a*b*2^-448 mod p.
// Start in cycle k, done pulses in cycle k+8; result holds until the next start.
module point_encode_mont_mul
  import parameters_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done
);

  logic [DATA_WIDTH-1:0] a_r, b_r;
  logic [DATA_WIDTH:0]   t, t_next;
  logic [2:0]            cnt;
  logic                  run;
  logic [63:0]           ai, m;
  logic [512:0]          ab, tsum, mp, sum;

  // p = -1 mod 2^64, so the per-digit quotient is just the low digit of t.
  always_comb begin
    ai     = a_r[63:0];
    ab     = 513'(ai) * 513'(b_r);
    tsum   = 513'(t) + ab;
    m      = tsum[63:0];
    mp     = (513'(m) << 448) - (513'(m) << 224) - 513'(m);
    sum    = tsum + mp;
    t_next = 449'(sum >> 64);
  end

  assign result = (t >= {1'b0, P}) ? (t[DATA_WIDTH-1:0] - P) : t[DATA_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      t    <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !run) begin
        a_r <= a;
        b_r <= b;
        t   <= '0;
        cnt <= '0;
        run <= 1'b1;
      end else if (run) begin
        t   <= t_next;
        a_r <= a_r >> 64;
        cnt <= cnt + 3'd1;
        if (cnt == 3'd6) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/point_encode.sv
// Projective Montgomery-form Ed448 point -> 456-bit encoding {x[0], 7'b0, y}.
// Inverts Z by Fermat exponentiation on one shared Montgomery multiplier.
module point_encode
  import parameters_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] X1,
  input  logic [DATA_WIDTH-1:0] Y1,
  input  logic [DATA_WIDTH-1:0] Z1,
  output logic [ENC_WIDTH-1:0]  enc,
  output logic                  done,
  output logic                  busy,
  output logic                  err
);

  enc_state_t state, state_n;

  logic [DATA_WIDTH-1:0] acc, xr, yr, x1r, y1r, z1r;
  logic [DATA_WIDTH-1:0] mm_a, mm_b, mm_res, x_c, y_c;
  logic [8:0]            bitc;
  logic                  issued, zero_z, valid, err_r;
  logic                  mm_start, mm_done, exp_bit, last_bit;

  assign exp_bit  = P_MINUS_2[bitc];
  assign last_bit = (bitc == 9'd0);
  assign x_c      = (xr >= P) ? (xr - P) : xr;
  assign y_c      = (yr >= P) ? (yr - P) : yr;
  assign enc      = valid ? {xr[0], 7'b0, yr} : '0;
  assign err      = err_r;

  point_encode_mont_mul u_mm (
    .clk    (clk),
    .rst    (rst),
    .start  (mm_start),
    .a      (mm_a),
    .b      (mm_b),
    .result (mm_res),
    .done   (mm_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // A zero Z is detected from the latched copy in the first busy cycle,
  // which keeps inputs off any combinational path and gives a 2-cycle err reply.
  always_comb begin
    state_n  = state;
    mm_start = 1'b0;
    mm_a     = acc;
    mm_b     = acc;
    done     = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE:    if (start) state_n = INV_SQR;
      INV_SQR: begin
        if (zero_z) state_n = DONE;
        else begin
          mm_start = !issued;
          if (mm_done) state_n = exp_bit ? INV_MUL : (last_bit ? MUL_X : INV_SQR);
        end
      end
      INV_MUL: begin
        mm_b     = z1r;
        mm_start = !issued;
        if (mm_done) state_n = last_bit ? MUL_X : INV_SQR;
      end
      MUL_X: begin
        mm_a     = x1r;
        mm_start = !issued;
        if (mm_done) state_n = MUL_Y;
      end
      MUL_Y: begin
        mm_a     = y1r;
        mm_start = !issued;
        if (mm_done) state_n = FROM_X;
      end
      FROM_X: begin
        mm_a     = xr;
        mm_b     = FIELD_ONE;
        mm_start = !issued;
        if (mm_done) state_n = FROM_Y;
      end
      FROM_Y: begin
        mm_a     = yr;
        mm_b     = FIELD_ONE;
        mm_start = !issued;
        if (mm_done) state_n = CANON;
      end
      CANON:   state_n = DONE;
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      xr     <= '0;
      yr     <= '0;
      x1r    <= '0;
      y1r    <= '0;
      z1r    <= '0;
      bitc   <= '0;
      issued <= 1'b0;
      zero_z <= 1'b0;
      valid  <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      if (mm_start)     issued <= 1'b1;
      else if (mm_done) issued <= 1'b0;
      case (state)
        IDLE: if (start) begin
          x1r    <= X1;
          y1r    <= Y1;
          z1r    <= Z1;
          zero_z <= (Z1 == '0);
          acc    <= R_MOD_P;
          bitc   <= 9'd447;
          valid  <= 1'b0;
          err_r  <= 1'b0;
        end
        INV_SQR: begin
          if (zero_z) err_r <= 1'b1;
          else if (mm_done) begin
            acc <= mm_res;
            if (!exp_bit && !last_bit) bitc <= bitc - 9'd1;
          end
        end
        INV_MUL: if (mm_done) begin
          acc <= mm_res;
          if (!last_bit) bitc <= bitc - 9'd1;
        end
        MUL_X:  if (mm_done) xr <= mm_res;
        MUL_Y:  if (mm_done) yr <= mm_res;
        FROM_X: if (mm_done) xr <= mm_res;
        FROM_Y: if (mm_done) yr <= mm_res;
        CANON: begin
          xr    <= x_c;
          yr    <= y_c;
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_point_encode.sv
// Scoreboard bench for point_encode: expected encodings come from plain modular
// arithmetic (x = X*Z^-1 mod p, y = Y*Z^-1 mod p) and are checked at each done.
module tb_point_encode;

  localparam int unsigned T_MM = 8;
  localparam int unsigned LAT  = 898 * (T_MM + 1) + 2;

  localparam logic [447:0] MP     = ~(448'd1 << 224);
  localparam logic [447:0] RR     = (448'd1 << 224) | 448'd1;
  localparam logic [447:0] R2     = (448'd1 << 225) | 448'd2;
  localparam logic [455:0] ENC_01 = 456'd1;
  localparam logic [455:0] ENC_11 = {1'b1, 7'd0, 448'd1};

  typedef struct {
    logic [455:0] enc;
    logic         err;
    int unsigned  cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [447:0] X1, Y1, Z1;
  logic [455:0] enc;
  logic         done, busy, err;

  exp_t         sb[$];
  int unsigned  cyc = 0;
  int unsigned  checks = 0;
  int unsigned  errors = 0;

  point_encode dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .X1    (X1),
    .Y1    (Y1),
    .Z1    (Z1),
    .enc   (enc),
    .done  (done),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [447:0] mulmod(input logic [447:0] a, input logic [447:0] b);
    logic [895:0] pr;
    pr = {448'd0, a} * {448'd0, b};
    pr = pr % {448'd0, MP};
    return pr[447:0];
  endfunction

  function automatic logic [447:0] inv_mod(input logic [447:0] z);
    logic [447:0] r, base, e;
    r    = 448'd1;
    base = z;
    e    = MP - 448'd2;
    while (e != '0) begin
      if (e[0]) r = mulmod(r, base);
      base = mulmod(base, base);
      e    = e >> 1;
    end
    return r;
  endfunction

  function automatic logic [455:0] model_enc(input logic [447:0] x, input logic [447:0] y,
                                             input logic [447:0] z);
    logic [447:0] zi, ax, ay;
    zi = inv_mod(z);
    ax = mulmod(x, zi);
    ay = mulmod(y, zi);
    return {ax[0], 7'd0, ay};
  endfunction

  function automatic logic [447:0] rand_fe();
    logic [447:0] v;
    for (int i = 0; i < 14; i++) v[i*32 +: 32] = $urandom;
    if (v >= MP) v = v - MP;
    return v;
  endfunction

  task automatic chk(input string name, input logic [455:0] act, input logic [455:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic issue(input logic [447:0] x, input logic [447:0] y, input logic [447:0] z,
                       input logic [455:0] e, input logic er, input int unsigned lat);
    @(negedge clk);
    X1 = x; Y1 = y; Z1 = z; start = 1'b1;
    sb.push_back('{e, er, cyc + lat});
    @(negedge clk);
    start = 1'b0;
    X1 = rand_fe(); Y1 = rand_fe(); Z1 = rand_fe();
    chk("busy_after_start", {455'd0, busy}, 456'd1);
  endtask

  task automatic drain(input int unsigned budget);
    for (int unsigned i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout pending=%0d want=0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    chk("busy_after_done", {455'd0, busy}, 456'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done cycle=%0d want=none", cyc);
        end else begin
          e = sb.pop_front();
          chk("enc", enc, e.enc);
          chk("err", {455'd0, err}, {455'd0, e.err});
          chk("latency", 456'(cyc), 456'(e.cyc));
          if (!e.err) chk("y_canonical", {455'd0, enc[447:0] < MP}, 456'd1);
        end
      end
    end
  end

  initial begin
    logic [447:0] px, py, pz;
    rst = 1'b1; start = 1'b0; X1 = '0; Y1 = '0; Z1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_enc", enc, 456'd0);
    chk("reset_busy", {455'd0, busy}, 456'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_done", {455'd0, done}, 456'd0);
    chk("idle_err", {455'd0, err}, 456'd0);

    issue(rand_fe(), rand_fe(), '0, 456'd0, 1'b1, 2);
    drain(20);

    issue('0, RR, RR, ENC_01, 1'b0, LAT);
    drain(LAT + 50);

    issue(R2, R2, R2, ENC_11, 1'b0, LAT);
    drain(LAT + 50);
    issue(RR, RR, RR, ENC_11, 1'b0, LAT);
    drain(LAT + 50);

    px = rand_fe(); py = rand_fe(); pz = rand_fe();
    if (pz == '0) pz = RR;
    issue(px, py, pz, model_enc(px, py, pz), 1'b0, LAT);
    drain(LAT + 50);

    // second start at cycle 100 of a running job must be ignored
    px = rand_fe(); py = rand_fe(); pz = rand_fe();
    if (pz == '0) pz = R2;
    issue(px, py, pz, model_enc(px, py, pz), 1'b0, LAT);
    repeat (99) @(negedge clk);
    X1 = rand_fe(); Y1 = rand_fe(); Z1 = RR; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(LAT + 50);
    repeat (30) @(negedge clk);

    // reset in the middle of the inversion
    issue(rand_fe(), rand_fe(), RR, 456'd0, 1'b0, LAT);
    repeat (300) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_enc", enc, 456'd0);
    chk("abort_done", {455'd0, done}, 456'd0);
    chk("abort_busy", {455'd0, busy}, 456'd0);
    chk("abort_err", {455'd0, err}, 456'd0);
    sb.delete();
    start = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("start_at_rst_release", {455'd0, busy}, 456'd0);

    px = rand_fe(); py = rand_fe(); pz = rand_fe();
    if (pz == '0) pz = RR;
    issue(px, py, pz, model_enc(px, py, pz), 1'b0, LAT);
    drain(LAT + 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/point_encode.md
# point_encode

Converts a projective Ed448 point in Montgomery form (X:Y:Z, the format produced by point_double and point_add) into the 456-bit Ed448 point encoding (RFC 8032 §5.2.2). This is the output end of the scalar-multiplication datapath, ahead of signature assembly. It computes Z⁻¹ by Fermat exponentiation, leaves the Montgomery domain, canonicalises, and packs y with the sign of x. It uses a single shared Montgomery multiplier.

## Interface
- DATA_WIDTH, 448 (parameters_pkg): field element width
- ENC_WIDTH, 456 (parameters_pkg): encoding width (57 bytes)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; X1/Y1/Z1 sampled on this edge when idle
- X1, Y1, Z1  in  DATA_WIDTH each  projective coordinates, Montgomery form (value·R mod p)
- enc  out  ENC_WIDTH  encoding as an integer: enc[447:0]=y, enc[454:448]=0, enc[455]=x[0]; byte 0 = enc[7:0] (little-endian serialisation is the consumer's job)
- done  out  1  one-cycle pulse; enc/err valid from this cycle until the next accepted start
- busy  out  1  high from the cycle after an accepted start through the done cycle
- err  out  1  valid with done; 1 iff Z1 == 0 (no inverse)

## Operation
- Reset values: enc=0, done=0, busy=0, err=0, FSM=IDLE.
- start is accepted only in IDLE and ignored while busy. Inputs are latched, so the caller may change them afterwards.
- Z1 == 0 at start: go directly to DONE with err=1 and enc=0; no multiplier activity.
- States: IDLE → INV_SQR ⇄ INV_MUL → MUL_X → MUL_Y → FROM_X → FROM_Y → CANON → DONE → IDLE.
- Inversion: acc ← R_MOD_P (Montgomery one). Scan E = P_MINUS_2 = 2^448−2^224−3 from bit 447 down to bit 0.
  - For each bit: INV_SQR computes acc ← mm(acc, acc).
  - If E[i]=1, INV_MUL then computes acc ← mm(acc, Z1).
  - The bit counter decrements after the bit's last op. The scan exits after bit 0.
  - Result: acc = Z⁻¹·R mod p.
- MUL_X: xm ← mm(X1, acc). MUL_Y: ym ← mm(Y1, acc).
- FROM_X: x ← mm(xm, 1). FROM_Y: y ← mm(ym, 1). Here mm(a,b) = a·b·R⁻¹ mod p, and the operand 1 is the plain integer.
- CANON (1 cycle): if x ≥ p then x −= p; if y ≥ p then y −= p. This holds even though mont_mul outputs are < 2p.
- DONE (1 cycle): drive enc, err=0, done=1.
- Op count: 448 squarings + popcount(E)=446 multiplies + 4 = 898 mm operations.
- A mid-operation rst aborts immediately to reset values. A start pulse coincident with rst release is ignored.

## Timing
- T_MM = cycles from mont_mul start to mont_mul done (mont_mul parameter).
- Each mm op costs T_MM+1 cycles: one cycle to issue start, then wait for done. The result is captured on the done cycle.
- Latency from the start edge to the done pulse is 898·(T_MM+1) + 2 cycles.
- Z1==0 case: done 2 cycles after the start edge.
- busy falls the cycle after done. A new start is accepted the same cycle busy is low.

## Structure
- parameters_pkg gains P_MINUS_2, ENC_WIDTH and the state typedef enc_state_t. It already holds DATA_WIDTH, P and R_MOD_P.
- One mont_mul instance, reused for all ops. Its operands are muxed by state, with no combinational path from inputs to enc.
- Registers: acc, xm/x, ym/y, 9-bit bit counter, FSM state, latched X1/Y1/Z1.

## Test plan
- Identity: X1=0, Y1=Z1=R_MOD_P → enc=456'h1, err=0; done at exactly 898·(T_MM+1)+2 cycles.
- Scale invariance: X1=Y1=Z1=(2·R) mod p, then X1=Y1=Z1=R_MOD_P → both give enc={1'b1,7'b0,448'h1}.
- Round trip: feed point_double output for the Ed448 base point → enc matches the RFC 8032 encoding of 2B from a software model. Also check canonical y < p.
- Z1=0 → done after 2 cycles, err=1, enc=0.
- start pulsed again at cycle 100 while busy → ignored; a single done arrives with the unchanged result.
- rst asserted mid-inversion → all outputs 0 next cycle. A fresh start then completes correctly with full latency.
